// File: rtl/dsp_preadd_mul.sv
// Signed pipelined (A +/- B) * C with a fixed 3-cycle latency, valid-qualified, no backpressure.
// Define DSP_PREADD_SUB_EN to add i_preadd_sub, which selects A-B instead of A+B in the pre-adder.
module dsp_preadd_mul #(
  parameter int VALUE_WIDTH = 32
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_in_valid,
  input  logic signed [VALUE_WIDTH-1:0]   i_preadd_a,
  input  logic signed [VALUE_WIDTH-1:0]   i_preadd_b,
  input  logic signed [VALUE_WIDTH-1:0]   i_mul,
`ifdef DSP_PREADD_SUB_EN
  input  logic                            i_preadd_sub,
`endif
  output logic signed [2*VALUE_WIDTH:0]   o_out,
  output logic                            o_out_valid
);

  localparam int SW = VALUE_WIDTH + 1;
  localparam int PW = 2*VALUE_WIDTH + 1;

  logic signed [VALUE_WIDTH-1:0] s1_a, s1_b, s1_c;
  logic                          s1_valid;
  logic                          s1_sub;
  logic signed [SW-1:0]          s2_sum;
  logic signed [VALUE_WIDTH-1:0] s2_c;
  logic                          s2_valid;

  logic signed [SW-1:0] ext_a, ext_b;
  logic signed [PW-1:0] mul_x, mul_y;

  // Operands are widened as signed values, so every extension copies the sign bit.
  assign ext_a = SW'(s1_a);
  assign ext_b = SW'(s1_b);
  assign mul_x = PW'(s2_sum);
  assign mul_y = PW'(s2_c);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
      s1_sub   <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= i_in_valid;
      if (i_in_valid) begin
        s1_a <= i_preadd_a;
        s1_b <= i_preadd_b;
        s1_c <= i_mul;
`ifdef DSP_PREADD_SUB_EN
        s1_sub <= i_preadd_sub;
`else
        s1_sub <= 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s2_sum   <= '0;
      s2_c     <= '0;
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sum <= s1_sub ? (ext_a - ext_b) : (ext_a + ext_b);
        s2_c   <= s1_c;
      end
    end
  end

  // A (W+1) x W signed product always fits in 2W+1 bits, so no saturation is needed.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_out       <= '0;
      o_out_valid <= 1'b0;
    end else begin
      o_out_valid <= s2_valid;
      if (s2_valid) begin
        o_out <= mul_x * mul_y;
      end
    end
  end

endmodule

// File: tb/tb_dsp_preadd_mul.sv
// Table-driven bench with a cycle-tagged scoreboard for dsp_preadd_mul (VALUE_WIDTH=32).
module tb_dsp_preadd_mul;

  localparam int W  = 32;
  localparam int PW = 2*W + 1;

  typedef struct {
    logic signed [W-1:0]  a;
    logic signed [W-1:0]  b;
    logic signed [W-1:0]  c;
    bit                   sub;
    logic signed [PW-1:0] exp;
  } vec_t;

  typedef struct {
    logic signed [PW-1:0] val;
    int                   due;
  } sb_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic signed [W-1:0]  a = '0, b = '0, c = '0;
`ifdef DSP_PREADD_SUB_EN
  logic                 sub = 1'b0;
`endif
  logic signed [PW-1:0] out;
  logic                 out_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  sb_t q[$];
  logic signed [PW-1:0] exp_last = '0;

  dsp_preadd_mul #(.VALUE_WIDTH(W)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_in_valid  (in_valid),
    .i_preadd_a  (a),
    .i_preadd_b  (b),
    .i_mul       (c),
`ifdef DSP_PREADD_SUB_EN
    .i_preadd_sub(sub),
`endif
    .o_out       (out),
    .o_out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name,
                       input logic signed [PW-1:0] act, input logic signed [PW-1:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Reset edges discard everything in flight and clear the held output.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      q.delete();
      exp_last = '0;
    end
  end

  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        check(1'b0, "unexpected_valid", out, exp_last);
      end else begin
        sb_t e;
        e = q.pop_front();
        check(out == e.val, "result", out, e.val);
        check(cyc == e.due, "latency", PW'(cyc), PW'(e.due));
        exp_last = e.val;
      end
    end else begin
      check(out == exp_last, "hold", out, exp_last);
      if (q.size() != 0 && q[0].due <= cyc) begin
        check(1'b0, "missing_valid", PW'(cyc), PW'(q[0].due));
        void'(q.pop_front());
      end
    end
  end

  function automatic logic signed [PW-1:0] model(input logic signed [W-1:0] x,
      input logic signed [W-1:0] y, input logic signed [W-1:0] z, input bit s);
    logic signed [PW-1:0] xe, ye, ze;
    xe = PW'(x); ye = PW'(y); ze = PW'(z);
    return (s ? (xe - ye) : (xe + ye)) * ze;
  endfunction

  task automatic drive(input vec_t v, input bit vld);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = vld;
    a = v.a; b = v.b; c = v.c;
`ifdef DSP_PREADD_SUB_EN
    sub = v.sub;
`endif
    if (vld) q.push_back('{val: v.exp, due: cyc + 3});
  endtask

  task automatic idle(input int n);
    vec_t junk;
    for (int i = 0; i < n; i++) begin
      junk.a = $urandom; junk.b = $urandom; junk.c = $urandom;
      junk.sub = 1'b0; junk.exp = '0;
      drive(junk, 1'b0);
    end
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    tbl.push_back('{a: 3,  b: 4, c: 5,  sub: 0, exp: 35});
    tbl.push_back('{a: 5,  b: 4, c: 5,  sub: 0, exp: 45});
    tbl.push_back('{a: -3, b: 4, c: -5, sub: 0, exp: -5});
    tbl.push_back('{a: 32'sh8000_0000, b: 32'sh8000_0000, c: 32'sh8000_0000, sub: 0,
                    exp: 65'sh0_8000_0000_0000_0000});
    tbl.push_back('{a: 32'sh7FFF_FFFF, b: 32'sh7FFF_FFFF, c: 32'sh8000_0000, sub: 0,
                    exp: -(65'sd9223372032559808512)});
    tbl.push_back('{a: -1, b: -1, c: -1, sub: 0, exp: 2});
    tbl.push_back('{a: 0,  b: 0,  c: 32'sh7FFF_FFFF, sub: 0, exp: 0});
    tbl.push_back('{a: 7,  b: -7, c: 123, sub: 0, exp: 0});

    // Reset held for two edges; check cleared outputs.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check(out == '0, "reset_out", out, '0);
    check(out_valid == 1'b0, "reset_valid", PW'(out_valid), '0);

    // Single isolated transaction.
    drive(tbl[0], 1'b1);
    idle(5);

    // Back-to-back table vectors.
    for (int i = 0; i < tbl.size(); i++) drive(tbl[i], 1'b1);
    idle(5);

    // Valid then invalid operands that must never reach the output.
    drive(tbl[1], 1'b1);
    v = '{a: 5, b: 6, c: 7, sub: 0, exp: 77};
    for (int i = 0; i < 6; i++) drive(v, 1'b0);

    // Reset one cycle after a valid input discards it.
    v = '{a: 9, b: 9, c: 9, sub: 0, exp: 162};
    drive(v, 1'b1);
    @(posedge clk); #1; in_valid = 1'b0; rst = 1'b1;
    v = '{a: 1, b: 1, c: 1, sub: 0, exp: 2};
    drive(v, 1'b1);
    idle(5);

`ifdef DSP_PREADD_SUB_EN
    v = '{a: 10, b: 3, c: 4, sub: 1, exp: 28};
    drive(v, 1'b1);
    v = '{a: 10, b: 3, c: 4, sub: 0, exp: 52};
    drive(v, 1'b1);
    v = '{a: 32'sh8000_0000, b: 32'sh8000_0000, c: -1, sub: 1, exp: 0};
    drive(v, 1'b1);
    idle(4);
`endif

    // Random operands with random bubbles.
    for (int i = 0; i < 40; i++) begin
      bit vld;
      v.a = $urandom; v.b = $urandom; v.c = $urandom;
`ifdef DSP_PREADD_SUB_EN
      v.sub = $urandom_range(0, 1);
`else
      v.sub = 1'b0;
`endif
      v.exp = model(v.a, v.b, v.c, v.sub);
      vld = ($urandom_range(0, 3) != 0);
      drive(v, vld);
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && q.size() != 0; i++) idle(1);
    idle(2);
    check(q.size() == 0, "drain", PW'(q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
